// File: rtl/spi_sequencer.sv
// Table-driven SPI transfer sequencer: plays the first N programmed words to an SPI
// master on a rising i_enable, spacing words with an idle gap and capturing each reply.
module spi_sequencer #(
  parameter int SPI_DATA_WIDTH = 8,
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic [$clog2(DEPTH+1)-1:0]   i_count,
  input  logic                         i_abort,
  input  logic                         i_cfg_wr,
  input  logic [$clog2(DEPTH)-1:0]     i_cfg_addr,
  input  logic [SPI_DATA_WIDTH-1:0]    i_cfg_data,
  input  logic [SPI_DATA_WIDTH-1:0]    i_data,
  input  logic                         i_done,
  input  logic                         i_busy,
  output logic                         o_enable,
  output logic [SPI_DATA_WIDTH-1:0]    o_data,
  output logic                         o_rd_valid,
  output logic [$clog2(DEPTH)-1:0]     o_rd_index,
  output logic [SPI_DATA_WIDTH-1:0]    o_rd_data,
  output logic                         o_busy,
  output logic                         o_seq_done
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t                    state_q, state_d;
  logic                      en_s1_q, en_s2_q, start_q;
  logic [CW-1:0]             count_q, count_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic                      enable_q, enable_d;
  logic [SPI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [IW-1:0]             rd_index_q, rd_index_d;
  logic [SPI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      seq_done_q, seq_done_d;
  logic [SPI_DATA_WIDTH-1:0] table_q [DEPTH];

  logic [CW-1:0] count_clamped;
  logic          last_word;
  logic          finish_word;

  assign count_clamped = (i_count > CW'(DEPTH)) ? CW'(DEPTH) : i_count;
  assign last_word     = (CW'(idx_q) == (count_q - CW'(1)));
  assign finish_word   = last_word || i_abort;

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_q && (count_clamped != '0)) state_d = XFER;
      XFER:    if (i_done) state_d = finish_word ? IDLE : GAP;
      GAP:     if ((gap_q == '0) && !i_busy) state_d = XFER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    count_d    = count_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    enable_d   = enable_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    rd_index_d = rd_index_q;
    rd_data_d  = rd_data_q;
    seq_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        data_d   = '0;
        if (start_q) begin
          if (count_clamped == '0) begin
            seq_done_d = 1'b1;
          end else begin
            count_d  = count_clamped;
            idx_d    = '0;
            enable_d = 1'b1;
            data_d   = table_q[0];
          end
        end
      end
      XFER: begin
        if (i_done) begin
          enable_d   = 1'b0;
          rd_valid_d = 1'b1;
          rd_index_d = idx_q;
          rd_data_d  = i_data;
          if (finish_word) begin
            seq_done_d = 1'b1;
            data_d     = '0;
          end else begin
            idx_d = idx_q + IW'(1);
            gap_d = GW'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        // The counter parks at zero; i_busy can then hold the gap open indefinitely.
        if (gap_q == '0) begin
          if (!i_busy) begin
            enable_d = 1'b1;
            data_d   = table_q[idx_q];
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        enable_d = 1'b0;
        data_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin : state_reg
    if (i_reset) begin
      state_q    <= IDLE;
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      start_q    <= 1'b0;
      count_q    <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      enable_q   <= 1'b0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_index_q <= '0;
      rd_data_q  <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_s1_q    <= i_enable;
      en_s2_q    <= en_s1_q;
      start_q    <= en_s1_q & ~en_s2_q;
      count_q    <= count_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      enable_q   <= enable_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      rd_index_q <= rd_index_d;
      rd_data_q  <= rd_data_d;
      seq_done_q <= seq_done_d;
    end
  end

  // Table survives reset; writes are blocked once a start is pending so word 0 cannot change under it.
  always_ff @(posedge i_clock) begin : table_wr
    if (i_cfg_wr && (state_q == IDLE) && !start_q && (int'(i_cfg_addr) < DEPTH)) begin
      table_q[i_cfg_addr] <= i_cfg_data;
    end
  end

  assign o_enable   = enable_q;
  assign o_data     = data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_index = rd_index_q;
  assign o_rd_data  = rd_data_q;
  assign o_busy     = (state_q != IDLE);
  assign o_seq_done = seq_done_q;

endmodule
